// File: rtl/posit_pkg.sv
// Shared posit constants and the decoded-operand record used by both encode and decode paths.
// Pure declarations: no latency, no flow control.
package posit_pkg;
  localparam int N  = 32;
  localparam int ES = 4;
  localparam int SW = $clog2(N) + ES + 2;
  localparam int FW = N;
  localparam int KW = SW - ES;
  localparam int RW = $clog2(N) + 1;
  localparam int BW = N + ES + FW;

  localparam logic signed [SW-1:0] MAXSCALE = SW'((N - 2) << ES);
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = N'(1);
  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic                 sign;
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
    logic                 sticky;
    logic                 zero;
    logic                 nar;
  } posit_dec_t;

  // Number of repeated regime bits before the terminating bit.
  function automatic logic [RW-1:0] regime_run(input logic signed [KW-1:0] k);
    return k[KW-1] ? RW'(-k) : RW'(k + KW'(1));
  endfunction
endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on a left-justified posit magnitude, clamped to [minpos, maxpos].
// Combinational, zero latency; no flow control.
module posit_round_rne
  import posit_pkg::*;
(
  input  logic [N-2:0] mag,
  input  logic         guard,
  input  logic         sticky,
  output logic [N-1:0] res
);
  logic         rnd_up;
  logic [N-1:0] sum;

  always_comb begin
    rnd_up = guard & (mag[0] | sticky);
    sum    = {1'b0, mag} + {{(N-1){1'b0}}, rnd_up};
    // A carry into the sign position would read as NaR, so pin it to maxpos.
    if (sum[N-1])
      res = MAXPOS;
    else if (sum == '0)
      res = MINPOS;
    else
      res = sum;
  end
endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage posit encoder: decoded operand in, RNE-rounded saturating posit out, 2-cycle latency.
// Valid/ready on both sides; stage 1 and the output register hold while the output is stalled.
module posit_encode_pipe
  import posit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic signed [SW-1:0] in_scale,
  input  logic [FW-1:0]        in_frac,
  input  logic                 in_sticky,
  input  logic                 in_zero,
  input  logic                 in_nar,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit
);
  localparam logic signed [SW-1:0] NEG_MAXSCALE = -MAXSCALE;

  logic in_fire, s1_adv;

  // stage-1 combinational
  logic                 sat_hi_c, sat_lo_c;
  logic signed [SW-1:0] scale_c;
  logic signed [KW-1:0] k_c;
  logic [ES-1:0]        e_c;

  // stage-1 registers
  logic                 s1_valid;
  posit_dec_t           s1_op;
  logic                 s1_sat_hi, s1_sat_lo;
  logic signed [KW-1:0] s1_k;
  logic [ES-1:0]        s1_e;
  logic [RW-1:0]        s1_run;

  // stage-2 combinational
  logic          r0;
  logic [BW-1:0] ones, body;
  logic [N-2:0]  mag;
  logic          guard, stk;
  logic [N-1:0]  rnd_res, mag_sel, enc;

  assign in_ready = !s1_valid | !out_valid | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign s1_adv   = s1_valid & (!out_valid | out_ready);

  always_comb begin
    sat_hi_c = (in_scale >= MAXSCALE);
    sat_lo_c = (in_scale <= NEG_MAXSCALE);
    if (sat_hi_c)
      scale_c = MAXSCALE;
    else if (sat_lo_c)
      scale_c = NEG_MAXSCALE;
    else
      scale_c = in_scale;
    // Upper bits of the scale are exactly scale >>> ES.
    k_c = scale_c[SW-1:ES];
    e_c = scale_c[ES-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_k      <= '0;
      s1_e      <= '0;
      s1_run    <= '0;
      out_valid <= 1'b0;
      out_posit <= '0;
    end else begin
      if (in_fire) begin
        s1_valid     <= 1'b1;
        s1_op.sign   <= in_sign;
        s1_op.scale  <= scale_c;
        s1_op.frac   <= in_frac;
        s1_op.sticky <= in_sticky;
        s1_op.zero   <= in_zero;
        s1_op.nar    <= in_nar;
        s1_sat_hi    <= sat_hi_c;
        s1_sat_lo    <= sat_lo_c;
        s1_k         <= k_c;
        s1_e         <= e_c;
        s1_run       <= regime_run(k_c);
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        out_valid <= 1'b1;
        out_posit <= enc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Regime run, terminator, exponent and fraction packed MSB-first just below the sign.
  always_comb begin
    r0    = !s1_k[KW-1];
    ones  = r0 ? ~({BW{1'b1}} >> s1_run) : '0;
    body  = ones | ({~r0, s1_e, s1_op.frac, {(N-1){1'b0}}} >> s1_run);
    mag   = body[BW-1 -: N-1];
    guard = body[BW-N];
    stk   = (|body[BW-N-1:0]) | s1_op.sticky;
  end

  posit_round_rne u_round (
    .mag    (mag),
    .guard  (guard),
    .sticky (stk),
    .res    (rnd_res)
  );

  always_comb begin
    mag_sel = rnd_res;
    enc     = '0;
    if (s1_sat_hi)
      mag_sel = MAXPOS;
    else if (s1_sat_lo)
      mag_sel = MINPOS;
    if (s1_op.nar)
      enc = NAR;
    else if (s1_op.zero)
      enc = '0;
    else
      enc = s1_op.sign ? (~mag_sel + N'(1)) : mag_sel;
  end
endmodule

// File: tb/tb_posit_encode_pipe.sv
// Directed-vector bench for posit_encode_pipe: table vectors, backpressure stream,
// full-rate streaming and mid-stream reset.
module tb_posit_encode_pipe;
  import posit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_sign = 1'b0;
  logic signed [SW-1:0] in_scale = '0;
  logic [FW-1:0]        in_frac = '0;
  logic                 in_sticky = 1'b0;
  logic                 in_zero = 1'b0;
  logic                 in_nar = 1'b0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [N-1:0]         out_posit;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  posit_encode_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  typedef struct {
    logic          sign;
    int            scale;
    logic [FW-1:0] frac;
    logic          sticky;
    logic          zero;
    logic          nar;
    logic [N-1:0]  expv;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic s, input int sc, input logic [FW-1:0] f, input logic st,
                     input logic z, input logic na, input logic [N-1:0] e);
    vec_t v;
    v.sign = s; v.scale = sc; v.frac = f; v.sticky = st; v.zero = z; v.nar = na; v.expv = e;
    tv.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    in_valid  = 1'b1;
    in_sign   = v.sign;
    in_scale  = SW'(v.scale);
    in_frac   = v.frac;
    in_sticky = v.sticky;
    in_zero   = v.zero;
    in_nar    = v.nar;
  endtask

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  initial begin
    logic [N-1:0] expq[$];
    logic [N-1:0] held;
    logic         stall;
    int           sent, recv;

    //  sign scale  frac          stk zero nar  expected
    add(0,    0,  32'h00000000, 0, 0, 0, 32'h40000000);
    add(1,    0,  32'h00000000, 0, 0, 0, 32'hC0000000);
    add(0,   16,  32'h00000000, 0, 0, 0, 32'h60000000);
    add(0,    0,  32'h00000040, 0, 0, 0, 32'h40000000);
    add(0,    0,  32'h000000C0, 0, 0, 0, 32'h40000002);
    add(0,    0,  32'h00000040, 1, 0, 0, 32'h40000001);
    add(0,  480,  32'h00000000, 0, 0, 0, 32'h7FFFFFFF);
    add(0,  600,  32'h00000000, 0, 0, 0, 32'h7FFFFFFF);
    add(0, -600,  32'h00000000, 0, 0, 0, 32'h00000001);
    add(1, -600,  32'h00000000, 0, 0, 0, 32'hFFFFFFFF);
    add(0,  479,  32'hFFFFFFFF, 0, 0, 0, 32'h7FFFFFFF);
    add(0,    5,  32'h12345678, 0, 1, 1, 32'h80000000);
    add(1,    7,  32'h00000000, 0, 1, 0, 32'h00000000);
    add(0, -480,  32'h00000000, 0, 0, 0, 32'h00000001);
    add(0,   -1,  32'h00000000, 0, 0, 0, 32'h3E000000);
    add(0,  -16,  32'h00000000, 0, 0, 0, 32'h20000000);
    add(0,  -17,  32'h00000000, 0, 0, 0, 32'h1F000000);
    add(0,    1,  32'h80000000, 0, 0, 0, 32'h43000000);
    add(1,    0,  32'h000000C0, 0, 0, 0, 32'hBFFFFFFE);
    add(0,  464,  32'h00000000, 0, 0, 0, 32'h7FFFFFFE);
    add(0, -465,  32'h00000000, 0, 0, 0, 32'h00000002);
    add(1,    3,  32'h00000000, 0, 0, 1, 32'h80000000);

    // Reset state
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_posit", out_posit, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // One operand at a time: transfer, then result two cycles later
    foreach (tv[i]) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(tv[i]);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (i == 0) chk1("lat_early_vld", out_valid, 1'b0);
      @(negedge clk);
      #1;
      chk1($sformatf("vec%0d_vld", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_dat", i), out_posit, tv[i].expv);
    end

    // Backpressure stream of 8 with randomly toggling out_ready
    @(negedge clk);
    in_valid = 1'b0;
    sent = 0; recv = 0; stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
      @(negedge clk);
      if (stall) begin
        chk1("stall_vld", out_valid, 1'b1);
        chk("stall_dat", out_posit, held);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 8) drive(tv[sent]);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("stream_extra", out_posit, 32'hDEADBEEF);
        else chk($sformatf("stream%0d_dat", recv), out_posit, expq.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(tv[sent].expv);
        sent++;
      end
      stall = out_valid && !out_ready;
      held  = out_posit;
    end
    chk("stream_count", N'(recv), N'(8));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Full-rate streaming: no bubbles
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (c < 4) drive(tv[8 + c]);
      else in_valid = 1'b0;
      #1;
      if (c < 4) chk1("full_rdy", in_ready, 1'b1);
      if (c >= 2 && c < 6) begin
        chk1($sformatf("full%0d_vld", c - 2), out_valid, 1'b1);
        chk($sformatf("full%0d_dat", c - 2), out_posit, tv[6 + c].expv);
      end
      if (c == 6) chk1("full_end_vld", out_valid, 1'b0);
    end

    // Reset with two operands in flight
    @(negedge clk);
    out_ready = 1'b1;
    drive(tv[2]);
    @(negedge clk);
    drive(tv[4]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk1("pre_rst_vld", out_valid, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_vld", out_valid, 1'b0);
    chk("mid_rst_dat", out_posit, '0);
    chk1("mid_rst_rdy", in_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk1("post_rst_quiet", out_valid, 1'b0);
      if (c == 0) chk1("post_rst_rdy", in_ready, 1'b1);
    end
    @(negedge clk);
    drive(tv[5]);
    #1;
    chk1("post_rst_in_rdy", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk1("post_rst_lat1", out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1("post_rst_lat2_vld", out_valid, 1'b1);
    chk("post_rst_lat2_dat", out_posit, tv[5].expv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_encode_pipe.md
# posit_encode_pipe

Two-stage pipelined posit encoder: accepts a decoded operand (sign, integer scale, MSB-aligned fraction, sticky, zero/NaR flags) and emits a correctly rounded N-bit posit with round-to-nearest-even and posit saturation. It is the packing direction of the posit decode done at the inputs of `Posit_Adder`. Arithmetic units hand their unrounded results to it through a valid/ready stream, and it sits in front of the result capture.

## Interface
- `N`, 32, posit width.
- `ES`, 4, exponent field width.
- `SW`, `$clog2(N)+ES+2` (=11), signed scale width.
- `FW`, N (=32), fraction width: hidden bit excluded, MSB-aligned.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input operand valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `in_sign`  in  1  1 = negative.
- `in_scale`  in  SW  signed value, k·2^ES + e.
- `in_frac`  in  FW  fraction bits after the hidden 1.
- `in_sticky`  in  1  OR of discarded bits below `in_frac`.
- `in_zero`  in  1  operand is exact zero.
- `in_nar`  in  1  operand is NaR; takes priority over `in_zero`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_posit`  out  N  encoded posit.

## Operation
- Transfer happens when valid and ready are both high, on either side.
- Stage 1 registers the following:
  - special flags;
  - the scale clamped to [−MAXSCALE, +MAXSCALE], where MAXSCALE = (N−2)·2^ES = 480;
  - the saturation flags `sat_hi` (scale ≥ 480) and `sat_lo` (scale ≤ −480);
  - k = scale >>> ES (arithmetic shift) and e = scale[ES−1:0];
  - the regime run length: k+1 ones then a 0 for k ≥ 0; −k zeros then a 1 for k < 0.
- Stage 2 builds {regime, e, in_frac} and left-justifies it below the sign bit. The top N−1 bits are kept.
  - guard = the next bit; sticky = OR(remaining bits) | `in_sticky`.
  - Round up iff guard & (lsb | sticky).
- Magnitude clamp: a carry past maxpos gives maxpos (0x7FFFFFFF). A zero magnitude gives minpos (0x00000001).
- Sign: if `in_sign`, the result is the two's complement of the magnitude.
- Specials:
  - `in_nar` gives 0x80000000.
  - `in_zero` gives 0x00000000, with the sign ignored.
  - `sat_hi` gives ±maxpos; `sat_lo` gives ±minpos.
  - Saturation never produces zero or NaR.

## Timing
- Latency: 2 cycles from input transfer to `out_valid`. Throughput is 1 result per cycle when `out_ready` is held high.
- `in_ready` = !s1_valid | (!out_valid | out_ready). It is combinational and has no dependency on `in_valid`.
- Stall: while `out_valid` & !`out_ready`, `out_posit` and `out_valid` hold stable. Stage 1 holds if it is full; no data is lost or duplicated.
- Simultaneous output transfer and stage-1 advance in the same cycle is legal. Full-rate streaming must show no bubbles.
- Reset (async, any time, including mid-stream):
  - `out_valid` = 0, `out_posit` = 0, stage-1 valid = 0;
  - in-flight data is discarded;
  - `in_ready` = 1 while in reset and from the first cycle after reset.
- Input fields are don't-care when `in_valid` = 0. Registers load only on transfer.

## Structure
- Shared package `posit_pkg` holds:
  - N, ES, SW, FW;
  - MAXSCALE;
  - MAXPOS = {1'b0, {N−1{1'b1}}}, MINPOS = 1, NAR = {1'b1, {N−1{1'b0}}};
  - a `posit_dec_t` struct {sign, scale, frac, sticky, zero, nar}, reused by the decode side.
- One sub-module, `posit_round_rne`: the combinational guard/sticky RNE increment plus the maxpos/minpos clamp. It is instantiated in stage 2.

## Test plan
- scale 0, frac 0, sign 0 → 0x40000000. The same with sign 1 → 0xC0000000. scale 16, frac 0 → 0x60000000.
- Rounding at scale 0:
  - frac 0x00000040 (tie, lsb 0) → 0x40000000;
  - frac 0x000000C0 → 0x40000002;
  - frac 0x00000040 with `in_sticky` = 1 → 0x40000001.
- Saturation:
  - scale 480 → 0x7FFFFFFF; scale 600 → 0x7FFFFFFF;
  - scale −600 → 0x00000001; scale −600 with sign 1 → 0xFFFFFFFF;
  - scale 479 (k = 29, e = 15), frac all ones → 0x7FFFFFFF (rounds to maxpos, never NaR).
- Specials: `in_nar` = 1 and `in_zero` = 1 → 0x80000000. `in_zero` only, sign 1 → 0x00000000.
- Backpressure: stream 8 operands with `out_ready` toggling pseudo-randomly. Outputs must appear in order with values matching a reference model and none dropped. `out_posit` must be stable during each stall.
- Reset: assert `rst_n` low with 2 operands in flight. `out_valid` drops immediately, nothing is emitted after release, `in_ready` = 1, and the next operand appears exactly 2 cycles after its transfer.
